// File: rtl/acorn_encrypt_core.sv
// ACORN-128 encryption core: absorbs associated data, pads, encrypts plaintext
// byte-serially (LSB first), pads again and presents the final 293-bit state
// to the tag stage. One state-update step per clock.
module acorn_encrypt_core #(
    parameter int LEN_W     = 16,
    parameter int PAD_STEPS = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [292:0]     state_in,
    input  logic [LEN_W-1:0] ad_len,
    input  logic [LEN_W-1:0] pt_len,
    input  logic [7:0]       ad_data,
    input  logic             ad_valid,
    output logic             ad_ready,
    input  logic [7:0]       pt_data,
    input  logic             pt_valid,
    output logic             pt_ready,
    output logic [7:0]       ct_data,
    output logic             ct_valid,
    input  logic             ct_ready,
    output logic             busy,
    output logic             done,
    output logic [292:0]     state_out
);

    typedef enum logic [2:0] {
        IDLE,
        AD,
        AD_PAD,
        PT,
        PT_PAD,
        DONE
    } state_t;

    localparam logic [8:0] LAST_PAD = 9'(PAD_STEPS - 1);
    localparam logic [8:0] HALF_PAD = 9'(PAD_STEPS / 2);

    state_t             fsm;
    logic [292:0]       s_reg;
    logic [LEN_W-1:0]   ad_len_q;
    logic [LEN_W-1:0]   pt_len_q;
    logic [LEN_W-1:0]   ad_cnt;
    logic [LEN_W-1:0]   pt_cnt;
    logic [8:0]         step_cnt;
    logic [6:0]         sh;
    logic [2:0]         sh_bits;
    logic [6:0]         ct_sh;
    logic               ad_slot;
    logic               pt_slot;

    logic               do_step;
    logic               m_bit;
    logic               ca;
    logic               cb;
    logic               ks;
    logic               ct_bit;
    logic [292:0]       s_next;
    logic               ad_fire;
    logic               pt_fire;
    logic               ct_fire;
    logic               pt_last_taken;

    // Majority and choose primitives of the ACORN update.
    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    // One ACORN step: returns {ks, next_state}. Keystream is taken after the
    // feedback corrections but before the shift.
    function automatic logic [293:0] acorn_step(
        input logic [292:0] s_in,
        input logic         m,
        input logic         c_a,
        input logic         c_b
    );
        logic [292:0] s;
        logic         k;
        logic         f;
        s      = s_in;
        s[289] = s[289] ^ s[235] ^ s[230];
        s[230] = s[230] ^ s[196] ^ s[193];
        s[193] = s[193] ^ s[160] ^ s[154];
        s[154] = s[154] ^ s[111] ^ s[107];
        s[107] = s[107] ^ s[66]  ^ s[61];
        s[61]  = s[61]  ^ s[23]  ^ s[0];
        k = s[12] ^ s[154] ^ maj(s[235], s[61], s[193]) ^ ch(s[230], s[111], s[66]);
        f = s[0] ^ ~s[107] ^ maj(s[244], s[23], s[160]) ^ (c_a & s[196]) ^ (c_b & k) ^ m;
        return {k, f, s[292:1]};
    endfunction

    assign ad_fire   = ad_valid & ad_ready;
    assign pt_fire   = pt_valid & pt_ready;
    assign ct_fire   = ct_valid & ct_ready;
    assign ad_ready  = ad_slot;
    // A new plaintext byte may enter in the same cycle the pending ct byte leaves.
    assign pt_ready  = pt_slot & (~ct_valid | ct_ready);
    assign state_out = s_reg;

    // Select message bit and control bits for the step taken this cycle.
    always_comb begin
        do_step       = 1'b0;
        m_bit         = 1'b0;
        ca            = 1'b0;
        cb            = 1'b0;
        pt_last_taken = (fsm == PT) && (sh_bits == 3'd0) && (pt_cnt == pt_len_q) && ct_fire;
        case (fsm)
            AD: begin
                ca = 1'b1;
                cb = 1'b1;
                if (sh_bits != 3'd0) begin
                    do_step = 1'b1;
                    m_bit   = sh[0];
                end else if (ad_fire) begin
                    do_step = 1'b1;
                    m_bit   = ad_data[0];
                end
            end
            AD_PAD: begin
                do_step = 1'b1;
                m_bit   = (step_cnt == '0);
                ca      = (step_cnt < HALF_PAD);
                cb      = 1'b1;
            end
            PT: begin
                ca = 1'b1;
                if (sh_bits != 3'd0) begin
                    do_step = 1'b1;
                    m_bit   = sh[0];
                end else if (pt_fire) begin
                    do_step = 1'b1;
                    m_bit   = pt_data[0];
                end else if (pt_last_taken) begin
                    // First padding step overlaps the final ct handshake.
                    do_step = 1'b1;
                    m_bit   = 1'b1;
                end
            end
            PT_PAD: begin
                do_step = 1'b1;
                m_bit   = (step_cnt == '0);
                ca      = (step_cnt < HALF_PAD);
            end
            default: ;
        endcase
    end

    // Evaluate the step function and the ciphertext bit.
    always_comb begin
        {ks, s_next} = acorn_step(s_reg, m_bit, ca, cb);
        ct_bit       = m_bit ^ ks;
    end

    // Phase sequencing, byte shifting, counters, state register and outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm      <= IDLE;
            s_reg    <= '0;
            ad_len_q <= '0;
            pt_len_q <= '0;
            ad_cnt   <= '0;
            pt_cnt   <= '0;
            step_cnt <= '0;
            sh       <= '0;
            sh_bits  <= '0;
            ct_sh    <= '0;
            ad_slot  <= 1'b0;
            pt_slot  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ct_valid <= 1'b0;
            ct_data  <= '0;
        end else begin
            done <= 1'b0;
            if (do_step) begin
                s_reg <= s_next;
            end
            case (fsm)
                IDLE: begin
                    if (start) begin
                        s_reg    <= state_in;
                        ad_len_q <= ad_len;
                        pt_len_q <= pt_len;
                        ad_cnt   <= '0;
                        pt_cnt   <= '0;
                        step_cnt <= '0;
                        sh       <= '0;
                        sh_bits  <= '0;
                        busy     <= 1'b1;
                        if (ad_len == '0) begin
                            fsm <= AD_PAD;
                        end else begin
                            fsm     <= AD;
                            ad_slot <= 1'b1;
                        end
                    end
                end
                AD: begin
                    if (sh_bits != 3'd0) begin
                        sh      <= {1'b0, sh[6:1]};
                        sh_bits <= sh_bits - 3'd1;
                        if (sh_bits == 3'd1) begin
                            if (ad_cnt == ad_len_q) begin
                                fsm      <= AD_PAD;
                                step_cnt <= '0;
                            end else begin
                                ad_slot <= 1'b1;
                            end
                        end
                    end else if (ad_fire) begin
                        sh      <= ad_data[7:1];
                        sh_bits <= 3'd7;
                        ad_cnt  <= ad_cnt + 1'b1;
                        ad_slot <= 1'b0;
                    end
                end
                AD_PAD: begin
                    step_cnt <= step_cnt + 9'd1;
                    if (step_cnt == LAST_PAD) begin
                        step_cnt <= '0;
                        if (pt_len_q == '0) begin
                            fsm <= PT_PAD;
                        end else begin
                            fsm     <= PT;
                            pt_slot <= 1'b1;
                        end
                    end
                end
                PT: begin
                    if (ct_fire) begin
                        ct_valid <= 1'b0;
                    end
                    if (sh_bits != 3'd0) begin
                        sh      <= {1'b0, sh[6:1]};
                        sh_bits <= sh_bits - 3'd1;
                        ct_sh   <= {ct_bit, ct_sh[6:1]};
                        if (sh_bits == 3'd1) begin
                            ct_data  <= {ct_bit, ct_sh};
                            ct_valid <= 1'b1;
                            pt_slot  <= (pt_cnt != pt_len_q);
                        end
                    end else if (pt_fire) begin
                        sh      <= pt_data[7:1];
                        sh_bits <= 3'd7;
                        ct_sh   <= {ct_bit, ct_sh[6:1]};
                        pt_cnt  <= pt_cnt + 1'b1;
                        pt_slot <= 1'b0;
                    end else if (pt_last_taken) begin
                        fsm      <= PT_PAD;
                        step_cnt <= 9'd1;
                    end
                end
                PT_PAD: begin
                    step_cnt <= step_cnt + 9'd1;
                    if (step_cnt == LAST_PAD) begin
                        step_cnt <= '0;
                        fsm      <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    fsm  <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acorn_encrypt_core.sv
// Self-checking bench for acorn_encrypt_core against a bit-array reference model.
module tb_acorn_encrypt_core;

    typedef logic [7:0] bq [$];

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [292:0] state_in;
    logic [15:0]  ad_len;
    logic [15:0]  pt_len;
    logic [7:0]   ad_data;
    logic         ad_valid;
    logic         ad_ready;
    logic [7:0]   pt_data;
    logic         pt_valid;
    logic         pt_ready;
    logic [7:0]   ct_data;
    logic         ct_valid;
    logic         ct_ready;
    logic         busy;
    logic         done;
    logic [292:0] state_out;

    int total = 0;
    int bad   = 0;

    int fb_d [6] = '{289, 230, 193, 154, 107, 61};
    int fb_a [6] = '{235, 196, 160, 111, 66, 23};
    int fb_b [6] = '{230, 193, 154, 107, 61, 0};
    bit ms [293];

    acorn_encrypt_core #(.LEN_W(16), .PAD_STEPS(256)) dut (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
        .ad_len(ad_len), .pt_len(pt_len),
        .ad_data(ad_data), .ad_valid(ad_valid), .ad_ready(ad_ready),
        .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .busy(busy), .done(done), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [292:0] obs, input logic [292:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit maj3(input bit x, input bit y, input bit z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic bit chs(input bit x, input bit y, input bit z);
        return x ? y : z;
    endfunction

    function automatic bit mstep(input bit m, input bit ca, input bit cb);
        bit k, f;
        for (int i = 0; i < 6; i++) ms[fb_d[i]] = ms[fb_d[i]] ^ ms[fb_a[i]] ^ ms[fb_b[i]];
        k = ms[12] ^ ms[154] ^ maj3(ms[235], ms[61], ms[193]) ^ chs(ms[230], ms[111], ms[66]);
        f = ms[0] ^ !ms[107] ^ maj3(ms[244], ms[23], ms[160]) ^ (ca & ms[196]) ^ (cb & k) ^ m;
        for (int j = 0; j < 292; j++) ms[j] = ms[j + 1];
        ms[292] = f;
        return k;
    endfunction

    task automatic model_run(input logic [292:0] s0, input bq adq, input bq ptq,
                             output logic [292:0] sf, output bq ctq);
        bit k;
        logic [7:0] c;
        ctq = {};
        for (int i = 0; i < 293; i++) ms[i] = s0[i];
        foreach (adq[n]) for (int b = 0; b < 8; b++) k = mstep(adq[n][b], 1'b1, 1'b1);
        for (int p = 0; p < 256; p++) k = mstep(p == 0, p < 128, 1'b1);
        foreach (ptq[n]) begin
            for (int b = 0; b < 8; b++) begin
                k = mstep(ptq[n][b], 1'b1, 1'b0);
                c[b] = ptq[n][b] ^ k;
            end
            ctq.push_back(c);
        end
        for (int p = 0; p < 256; p++) k = mstep(p == 0, p < 128, 1'b0);
        for (int i = 0; i < 293; i++) sf[i] = ms[i];
    endtask

    function automatic logic [292:0] rnd_state();
        logic [292:0] r;
        for (int i = 0; i < 293; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Drives one full operation from start to done; called at posedge+1.
    task automatic run(input string nm, input logic [292:0] s0, input bq adq, input bq ptq,
                       input int gap, input int stall, input bit restart, input int exp_lat);
        bq exp_ct, got;
        logic [292:0] exp_s, snap_s;
        logic [7:0] snap_c;
        int ai = 0, pti = 0, cyc = 0, lat = -1, viol = 0, sviol = 0, stall_left = 0, ctv_seen = 0;
        bit stall_used = 0, stalled_prev = 0;
        model_run(s0, adq, ptq, exp_s, exp_ct);
        state_in = s0;
        ad_len   = 16'(adq.size());
        pt_len   = 16'(ptq.size());
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < 5000) begin
            if (stalled_prev && (ct_data !== snap_c || state_out !== snap_s || ct_valid !== 1'b1)) sviol++;
            if (done === 1'b1) begin
                lat = cyc;
                break;
            end
            if (ct_valid === 1'b1) ctv_seen++;
            if (ct_valid === 1'b1 && stall > 0 && !stall_used) begin
                stall_used = 1;
                stall_left = stall;
                snap_c = ct_data;
                snap_s = state_out;
            end
            ct_ready = (stall_left == 0);
            ad_valid = (ai < adq.size()) && (cyc % gap == 0);
            ad_data  = (ai < adq.size()) ? adq[ai] : 8'($urandom);
            pt_valid = (pti < ptq.size());
            pt_data  = (pti < ptq.size()) ? ptq[pti] : 8'($urandom);
            if (restart && cyc == 100) begin
                start = 1'b1;
                state_in = ~s0;
                ad_len = 16'd7;
                pt_len = 16'd9;
            end else begin
                start = 1'b0;
            end
            #1;
            if (ai < adq.size() && pt_ready === 1'b1) viol++;
            if (pti > 0 && ad_ready === 1'b1) viol++;
            if (ad_valid && ad_ready === 1'b1) ai++;
            if (pt_valid && pt_ready === 1'b1) pti++;
            if (ct_valid === 1'b1 && ct_ready) got.push_back(ct_data);
            stalled_prev = (stall_left > 0);
            if (stall_left > 0) begin
                if (pt_ready !== 1'b0) sviol++;
                stall_left--;
            end
            @(posedge clk); #1;
            cyc++;
        end
        ad_valid = 1'b0;
        pt_valid = 1'b0;
        ct_ready = 1'b1;
        chk({nm, "_done_seen"}, lat >= 0, 1);
        if (exp_lat >= 0) chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_state_out"}, state_out, exp_s);
        chk({nm, "_ct_count"}, got.size(), exp_ct.size());
        for (int i = 0; i < exp_ct.size(); i++)
            if (i < got.size()) chk($sformatf("%s_ct%0d", nm, i), got[i], exp_ct[i]);
        chk({nm, "_ad_taken"}, ai, adq.size());
        chk({nm, "_pt_taken"}, pti, ptq.size());
        chk({nm, "_wrong_phase_ready"}, viol, 0);
        if (ptq.size() == 0) chk({nm, "_no_ct_valid"}, ctv_seen, 0);
        if (stall > 0) begin
            chk({nm, "_stall_seen"}, stall_used, 1);
            chk({nm, "_stall_hold"}, sviol, 0);
        end
        @(posedge clk); #1;
        chk({nm, "_done_pulse_end"}, {busy, done}, 2'b00);
        chk({nm, "_state_held"}, state_out, exp_s);
    endtask

    initial begin
        bq a, p;
        int k, ones;
        rst = 1'b0; start = 1'b0; state_in = '0; ad_len = '0; pt_len = '0;
        ad_data = '0; ad_valid = 1'b0; pt_data = '0; pt_valid = 1'b0; ct_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", {busy, done, ad_ready, pt_ready, ct_valid, ct_data}, '0);
        chk("reset_state", state_out, '0);
        rst = 1'b1;
        @(posedge clk); #1;

        a = {}; p = {};
        run("empty", rnd_state(), a, p, 1, 0, 0, 513);

        a = {8'h00}; p = {8'h00};
        run("one_one", rnd_state(), a, p, 1, 0, 0, 529);

        a = {8'($urandom), 8'($urandom)}; p = {8'h01, 8'h02, 8'h03, 8'h04};
        run("ct_stall", rnd_state(), a, p, 1, 20, 0, 581);

        a = {8'($urandom), 8'($urandom), 8'($urandom)}; p = {8'($urandom), 8'($urandom)};
        run("ad_gap", rnd_state(), a, p, 3, 0, 0, -1);

        a = {8'($urandom)}; p = {8'($urandom), 8'($urandom)};
        run("restart_ignored", rnd_state(), a, p, 1, 0, 1, 537);

        // Asynchronous reset in the middle of a plaintext byte.
        state_in = rnd_state(); ad_len = 16'd0; pt_len = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; pt_valid = 1'b1; pt_data = 8'($urandom); ct_ready = 1'b1;
        k = 0;
        while (k < 600) begin
            #1;
            if (pt_ready === 1'b1) break;
            @(posedge clk); #1;
            k++;
        end
        chk("rst_pt_phase_reached", pt_ready, 1);
        @(posedge clk); #1;
        pt_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_ctrl", {busy, done, ad_ready, pt_ready, ct_valid, ct_data}, '0);
        chk("rst_mid_state", state_out, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        ones = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ct_valid !== 1'b0 || busy !== 1'b0) ones++;
        end
        chk("rst_stays_idle", ones, 0);

        a = {}; p = {};
        run("after_reset", rnd_state(), a, p, 1, 0, 0, 513);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
